// File: rtl/alu_ctrl_pkg.sv
// Shared constants and FSM state type for the ALU controller with RV32M support.
package alu_ctrl_pkg;

    // Base ALU Operation codes
    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SLT  = 4'b0101;
    localparam logic [3:0] OP_SLL  = 4'b0110;
    localparam logic [3:0] OP_SRL  = 4'b0111;
    localparam logic [3:0] OP_SRA  = 4'b1000;
    localparam logic [3:0] OP_BEQ  = 4'b1001;
    localparam logic [3:0] OP_BNE  = 4'b1010;
    localparam logic [3:0] OP_BLT  = 4'b1011;
    localparam logic [3:0] OP_BGE  = 4'b1100;
    localparam logic [3:0] OP_SLTU = 4'b1101;
    localparam logic [3:0] OP_BLTU = 4'b1110;
    localparam logic [3:0] OP_BGEU = 4'b1111;

    // M-extension Funct3 codes
    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    // Opcodes and Funct7 patterns
    localparam logic [6:0] OPC_RTYPE = 7'b0110011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MEXT   = 7'b0000001;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MUL  = 3'd1,
        S_DIV  = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

endpackage

// File: rtl/alu_ctrl_mext_muldiv.sv
// Iterative unsigned multiply/divide datapath driven by strobes from alu_ctrl_mext.
// Optional macro ALU_CTRL_MUL_EARLY_OUT_EN: end a multiply once no multiplier bits remain.
module muldiv_iter #(
    parameter int unsigned XLEN = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                start_div,
    input  logic                mul_step,
    input  logic                div_step,
    input  logic [XLEN-1:0]     abs_a,
    input  logic [XLEN-1:0]     abs_b,
    output logic                last_c,
    output logic                mul_exit_c,
    output logic [2*XLEN-1:0]   acc
);

    localparam int unsigned CW = $clog2(XLEN + 1);
    localparam int unsigned PW = 2 * XLEN;

    // mcand: left-shifting multiplicand (mul) or divisor in the low half (div)
    logic [CW-1:0]   cnt;
    logic [PW-1:0]   mcand;
    logic [XLEN-1:0] mplier;
    logic [XLEN:0]   trial;
    logic [XLEN+1:0] diff;

    // Restoring-divide trial subtract; acc holds {remainder, quotient/dividend}
    always_comb begin
        trial = {acc[PW-1:XLEN], acc[XLEN-1]};
        diff  = {1'b0, trial} - {2'b00, mcand[XLEN-1:0]};
    end

    assign last_c = (cnt == CW'(1));

    // Multiply exit: counter expiry, optionally also when the remaining multiplier is zero
`ifdef ALU_CTRL_MUL_EARLY_OUT_EN
    assign mul_exit_c = last_c || (mplier[XLEN-1:1] == '0);
`else
    assign mul_exit_c = last_c;
`endif

    // Datapath registers: load on start, one bit per step
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else if (start) begin
            cnt    <= CW'(XLEN);
            mplier <= abs_b;
            mcand  <= {{XLEN{1'b0}}, (start_div ? abs_b : abs_a)};
            acc    <= start_div ? {{XLEN{1'b0}}, abs_a} : '0;
        end else if (mul_step) begin
            acc    <= acc + (mplier[0] ? mcand : '0);
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt - CW'(1);
        end else if (div_step) begin
            acc    <= diff[XLEN+1] ? {trial[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                                   : {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
            cnt    <= cnt - CW'(1);
        end
    end

endmodule

// File: rtl/alu_ctrl_mext.sv
// ALU controller: combinational base Operation decode plus a multi-cycle RV32M engine.
// Optional macro ALU_CTRL_MUL_EARLY_OUT_EN (handled in muldiv_iter) shortens multiplies.
module alu_ctrl_mext
    import alu_ctrl_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned OPW  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [1:0]       ALUOp,
    input  logic [6:0]       Funct7,
    input  logic [2:0]       Funct3,
    input  logic [6:0]       Opcode,
    input  logic             flush,
    input  logic [XLEN-1:0]  src_a,
    input  logic [XLEN-1:0]  src_b,
    output logic [OPW-1:0]   Operation,
    output logic             m_busy,
    output logic             m_done,
    output logic [XLEN-1:0]  m_result
);

    localparam int unsigned PW = 2 * XLEN;
    localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

    state_t            state, state_n;
    logic [3:0]        op4;
    logic              is_m, sa, sb, neg_a, neg_b, div0, ovf;
    logic [XLEN-1:0]   abs_a, abs_b, fast_val, res_n, fixed_res;
    logic              start, mul_step, div_step, load_res;
    logic              last_c, mul_exit_c;
    logic [PW-1:0]     acc, prod_fix;
    logic [2:0]        op_q;
    logic              neg_a_q, neg_b_q;

    assign is_m = (Opcode == OPC_RTYPE) && (Funct7 == F7_MEXT);

    // Base ALU operation decode
    always_comb begin
        op4 = OP_ADD;
        if (is_m) begin
            op4 = OP_AND;
        end else if (Opcode == OPC_LUI || Opcode == OPC_AUIPC) begin
            op4 = OP_ADD;
        end else if (ALUOp == 2'b00) begin
            op4 = OP_ADD;
        end else if (ALUOp == 2'b01) begin
            case (Funct3)
                3'b000:  op4 = OP_BEQ;
                3'b001:  op4 = OP_BNE;
                3'b100:  op4 = OP_BLT;
                3'b101:  op4 = OP_BGE;
                3'b110:  op4 = OP_BLTU;
                3'b111:  op4 = OP_BGEU;
                default: op4 = OP_ADD;
            endcase
        end else begin
            case (Funct3)
                3'b000:  op4 = (ALUOp == 2'b10 && Funct7 == F7_ALT) ? OP_SUB : OP_ADD;
                3'b001:  op4 = OP_SLL;
                3'b010:  op4 = OP_SLT;
                3'b011:  op4 = OP_SLTU;
                3'b100:  op4 = OP_XOR;
                3'b101:  op4 = (Funct7 == F7_ALT) ? OP_SRA : OP_SRL;
                3'b110:  op4 = OP_OR;
                default: op4 = OP_AND;
            endcase
        end
    end

    assign Operation = OPW'(op4);

    // Operand signedness, magnitudes and fast-path (div by zero / overflow) results
    always_comb begin
        case (Funct3)
            F3_MUL, F3_MULH, F3_DIV, F3_REM: begin sa = 1'b1; sb = 1'b1; end
            F3_MULHSU:                       begin sa = 1'b1; sb = 1'b0; end
            F3_MULHU, F3_DIVU, F3_REMU:      begin sa = 1'b0; sb = 1'b0; end
            default:                         begin sa = 1'b0; sb = 1'b0; end
        endcase
        neg_a    = sa && src_a[XLEN-1];
        neg_b    = sb && src_b[XLEN-1];
        abs_a    = neg_a ? -src_a : src_a;
        abs_b    = neg_b ? -src_b : src_b;
        div0     = Funct3[2] && (src_b == '0);
        ovf      = Funct3[2] && !Funct3[0] && (src_a == XMIN) && (src_b == '1);
        fast_val = div0 ? (Funct3[1] ? src_a : '1) : (Funct3[1] ? '0 : XMIN);
    end

    // Two's-complement sign correction of the unsigned engine result
    always_comb begin
        prod_fix = (neg_a_q ^ neg_b_q) ? -acc : acc;
        case (op_q)
            F3_MUL:                      fixed_res = prod_fix[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: fixed_res = prod_fix[PW-1:XLEN];
            F3_DIV, F3_DIVU:             fixed_res = (neg_a_q ^ neg_b_q) ? -acc[XLEN-1:0]
                                                                           : acc[XLEN-1:0];
            default:                     fixed_res = neg_a_q ? -acc[PW-1:XLEN] : acc[PW-1:XLEN];
        endcase
    end

    // Next-state and engine strobes; flush overrides everything
    always_comb begin
        state_n  = state;
        start    = 1'b0;
        mul_step = 1'b0;
        div_step = 1'b0;
        load_res = 1'b0;
        res_n    = fixed_res;
        case (state)
            S_IDLE: begin
                if (in_valid && is_m && !flush) begin
                    start = 1'b1;
                    if (div0 || ovf) begin
                        state_n  = S_DONE;
                        load_res = 1'b1;
                        res_n    = fast_val;
                    end else begin
                        state_n = Funct3[2] ? S_DIV : S_MUL;
                    end
                end
            end
            S_MUL: begin
                mul_step = 1'b1;
                if (mul_exit_c) state_n = S_FIX;
            end
            S_DIV: begin
                div_step = 1'b1;
                if (last_c) state_n = S_FIX;
            end
            S_FIX: begin
                load_res = 1'b1;
                state_n  = S_DONE;
            end
            default: state_n = S_IDLE;
        endcase
        if (flush) begin
            state_n  = S_IDLE;
            load_res = 1'b0;
        end
    end

    // State, latched op info and result register
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            m_result <= '0;
            op_q     <= '0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
        end else begin
            state <= state_n;
            if (start) begin
                op_q    <= Funct3;
                neg_a_q <= neg_a;
                neg_b_q <= neg_b;
            end
            if (load_res) m_result <= res_n;
        end
    end

    assign m_busy = (state == S_IDLE && in_valid && is_m) ||
                    (state == S_MUL) || (state == S_DIV) || (state == S_FIX);
    assign m_done = (state == S_DONE) && !flush;

    muldiv_iter #(.XLEN(XLEN)) u_iter (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .start_div  (Funct3[2]),
        .mul_step   (mul_step),
        .div_step   (div_step),
        .abs_a      (abs_a),
        .abs_b      (abs_b),
        .last_c     (last_c),
        .mul_exit_c (mul_exit_c),
        .acc        (acc)
    );

endmodule
